// File: rtl/lcd_value_formatter.sv
// Formats three binary readings (SpO2, heart rate, power) into a 21-character ASCII frame
// sent over a valid/ready character stream. Define LCD_FMT_ZERO_BLANK_EN to blank leading zeros.
module lcd_value_formatter #(
  parameter logic [7:0] SEP_CHAR = 8'h20,
  parameter logic [7:0] EOL_CHAR = 8'h0D
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [11:0] LCD_SPO2,
  input  logic [11:0] LCD_HEART,
  input  logic [19:0] LCD_WATT,
  input  logic        LCD_STB,
  output logic [7:0]  CHAR_DATA,
  output logic        CHAR_VALID,
  input  logic        CHAR_READY,
  output logic        CHAR_LAST,
  output logic        BUSY,
  output logic [7:0]  DROP_CNT
);

  typedef enum logic [1:0] {IDLE, CONV, SEND} state_t;

  localparam int NFLD     = 3;
  localparam int CONV_LEN = 20;
  localparam int LAST_IDX = 20;

  state_t                      state_q;
  logic                        stb_q;
  logic [NFLD-1:0][19:0]       bin_q;
  logic [NFLD-1:0][27:0]       bcd_q;
  logic [NFLD-1:0][27:0]       bcd_d;
  logic [4:0]                  cnt_q;
  logic [4:0]                  idx_q;
  logic [4:0]                  idx_d;
  logic [11:0]                 sh_spo_q;
  logic [11:0]                 sh_hr_q;
  logic [19:0]                 sh_w_q;
  logic                        pend_q;
  logic [7:0]                  drop_q;
  logic [7:0]                  data_q;
  logic                        valid_q;
  logic                        last_q;
  logic                        busy_q;
  logic                        rise;
  logic [LAST_IDX:0][7:0]      frame;

  // One double-dabble step: add 3 to every nibble >= 5, then shift in the next binary bit.
  function automatic logic [27:0] dd_step(input logic [27:0] b, input logic in);
    logic [27:0] a;
    for (int i = 0; i < 7; i++) begin
      a[i*4 +: 4] = (b[i*4 +: 4] >= 4'd5) ? b[i*4 +: 4] + 4'd3 : b[i*4 +: 4];
    end
    return (a << 1) | {27'h0, in};
  endfunction

  function automatic logic [7:0] digit_char(input logic [27:0] bcd, input int pos);
    logic [7:0] c;
    c = 8'h30 + {4'h0, bcd[pos*4 +: 4]};
`ifdef LCD_FMT_ZERO_BLANK_EN
    // A digit is leading-zero when it and everything above it is zero; the units digit never blanks.
    if (pos != 0 && (bcd >> (pos*4)) == 28'h0) c = 8'h20;
`endif
    return c;
  endfunction

  assign rise  = LCD_STB & ~stb_q;
  assign idx_d = idx_q + 5'd1;

  always_comb begin
    for (int k = 0; k < NFLD; k++) begin
      bcd_d[k] = dd_step(bcd_q[k], bin_q[k][19]);
    end
  end

  always_comb begin
    frame = '0;
    frame[0] = 8'h53;
    for (int j = 0; j < 4; j++) frame[1 + j] = digit_char(bcd_q[0], 3 - j);
    frame[5] = SEP_CHAR;
    frame[6] = 8'h48;
    for (int j = 0; j < 4; j++) frame[7 + j] = digit_char(bcd_q[1], 3 - j);
    frame[11] = SEP_CHAR;
    frame[12] = 8'h57;
    for (int j = 0; j < 7; j++) frame[13 + j] = digit_char(bcd_q[2], 6 - j);
    frame[LAST_IDX] = EOL_CHAR;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      stb_q    <= 1'b1;
      bin_q    <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      sh_spo_q <= '0;
      sh_hr_q  <= '0;
      sh_w_q   <= '0;
      pend_q   <= 1'b0;
      drop_q   <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      stb_q <= LCD_STB;
      if (rise && state_q != IDLE) begin
        sh_spo_q <= LCD_SPO2;
        sh_hr_q  <= LCD_HEART;
        sh_w_q   <= LCD_WATT;
        pend_q   <= 1'b1;
        if (pend_q && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
      end
      case (state_q)
        IDLE: begin
          if (rise) begin
            bin_q   <= {{8'h0, LCD_SPO2}, {8'h0, LCD_HEART}, LCD_WATT};
            bin_q[0] <= {8'h0, LCD_SPO2};
            bin_q[1] <= {8'h0, LCD_HEART};
            bin_q[2] <= LCD_WATT;
            bcd_q   <= '0;
            cnt_q   <= '0;
            state_q <= CONV;
            busy_q  <= 1'b1;
          end
        end
        CONV: begin
          for (int k = 0; k < NFLD; k++) begin
            bcd_q[k] <= bcd_d[k];
            bin_q[k] <= {bin_q[k][18:0], 1'b0};
          end
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'(CONV_LEN - 1)) begin
            state_q <= SEND;
            idx_q   <= '0;
          end
        end
        SEND: begin
          if (!valid_q) begin
            data_q  <= frame[idx_q];
            valid_q <= 1'b1;
            last_q  <= (idx_q == 5'(LAST_IDX));
          end else if (CHAR_READY) begin
            if (last_q) begin
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              // An edge on this same clock counts as pending and wins over the older shadow.
              if (pend_q || rise) begin
                bin_q[0] <= {8'h0, (rise ? LCD_SPO2  : sh_spo_q)};
                bin_q[1] <= {8'h0, (rise ? LCD_HEART : sh_hr_q)};
                bin_q[2] <= rise ? LCD_WATT : sh_w_q;
                bcd_q    <= '0;
                cnt_q    <= '0;
                pend_q   <= 1'b0;
                state_q  <= CONV;
              end else begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end
            end else begin
              idx_q  <= idx_d;
              data_q <= frame[idx_d];
              last_q <= (idx_d == 5'(LAST_IDX));
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign CHAR_DATA  = data_q;
  assign CHAR_VALID = valid_q;
  assign CHAR_LAST  = last_q;
  assign BUSY       = busy_q;
  assign DROP_CNT   = drop_q;

endmodule
